serial_sub8: RTL and testbench

Bit-serial subtractor computing diff = a - b - bin, one bit per clock, with a valid/ready handshake on both sides. It is the inverse-direction companion of the team's combinational ripple adder. It reuses a single one-bit cell instead of WIDTH parallel cells. It sits in the datapath where area matters more than latency, e.g. an accumulator decrement or a compare unit.

---
 rtl/serial_arith_pkg.sv | 19 +
 rtl/serial_sub8_bit_subtractor.sv | 20 ++
 rtl/serial_sub8.sv | 103 ++++++++++
 tb/tb_serial_sub8.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// ----------------------------------------------------------------------------
// serial_arith_pkg : shared state encoding and widths for bit-serial arithmetic
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package serial_arith_pkg;

  localparam int SERIAL_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_sub8_bit_subtractor.sv
// ----------------------------------------------------------------------------
// bit_subtractor : one-bit full subtractor cell (d = a - b - bin, borrow bo)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bit_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_sub8.sv
// ----------------------------------------------------------------------------
// serial_sub8 : bit-serial subtractor, diff = a - b - bin, LSB first, valid/ready
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_sub8
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bo;
  logic [WIDTH-1:0] shifted;

  bit_subtractor u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (borrow),
    .d   (d),
    .bo  (bo)
  );

  // Only the upper WIDTH-1 result bits need storing; the newest bit comes from the cell.
  assign shifted  = {d, res_sr};
  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            // On the last bit a_sr[0]/b_sr[0] are the original operand MSBs.
            diff      <= shifted;
            bout      <= bo;
            ovf       <= (a_sr[0] != b_sr[0]) && (d != a_sr[0]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            res_sr <= shifted[WIDTH-1:1];
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            borrow <= bo;
            cnt    <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_sub8.sv
// ----------------------------------------------------------------------------
// tb_serial_sub8 : directed-vector scoreboard bench for serial_sub8
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_sub8;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  serial_sub8 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares each result as it is handed off to the consumer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_result: got diff 0x%0h, expected no result", diff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("bout", 32'(bout), 32'(e.bo));
        check("ovf",  32'(ovf),  32'(e.ov));
      end
    end
  end

  // Drives one operand set (called at posedge+1); returns after the accepting edge.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                       input logic [7:0] ed, input logic eb, input logic eo, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    if (push) sb.push_back('{d: ed, bo: eb, ov: eo});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'hA5; b = 8'h3C; bin = 1'b1;   // scrambled: must not affect the operation
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 40);
    check("latency", 32'(n), 32'd8);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff",      32'(diff),      32'h00);
    check("rst_bout",      32'(bout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1); wait_result();
    issue(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1); wait_result();
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1); wait_result();
    issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1); wait_result();
    issue(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); wait_result();

    // Backpressure: result must hold and new operands must be ignored.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(8'h20, 8'h30, 1'b1, 8'hEF, 1'b1, 1'b0, 1'b1); wait_result();
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_diff",      32'(diff),      32'hEF);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      if (i == 2) begin
        a = 8'h44; b = 8'h11; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready",  32'(in_ready),  32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);
    issue(8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1); wait_result();

    // Reset during the 4th SHIFT cycle abandons the operation.
    @(posedge clk); #1;
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_diff",      32'(diff),      32'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1); wait_result();

    repeat (12) begin
      @(posedge clk); #1;
    end
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    check("final_out_valid",  32'(out_valid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
